// File: rtl/stopwatch_control_pkg.sv
// Shared definitions for the stopwatch run/pause/lap/clear controller:
// FSM state encoding and BCD digit geometry.
package stopwatch_control_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      LAP     = 2'd3
   } state_t;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int TIME_W     = DIGIT_W * NUM_DIGITS;

endpackage

// File: rtl/stopwatch_control_button_conditioner.sv
// Raw push-button to one-cycle press pulse: optional inversion, 2-flop
// synchroniser, saturating debounce counter, registered rising-edge detect.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pressed
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          raw;
   logic          sync1;
   logic          sync2;
   logic          accepted;
   logic          accepted_d;
   logic [CW-1:0] count;

   assign raw = ACTIVE_LOW ? ~in : in;

   // The counter only runs while the synchronised level disagrees with the
   // accepted one, so it restarts on every bounce and stops at LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         accepted   <= 1'b0;
         accepted_d <= 1'b0;
         count      <= '0;
         pressed    <= 1'b0;
      end else begin
         sync1      <= raw;
         sync2      <= sync1;
         accepted_d <= accepted;
         pressed    <= accepted & ~accepted_d;
         if (sync2 == accepted) begin
            count <= '0;
         end else if (count == LAST) begin
            accepted <= sync2;
            count    <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch front end: conditions the two buttons, sequences
// IDLE/RUNNING/PAUSED/LAP, gates the second tick and picks live or lap time.
module stopwatch_control
   import stopwatch_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1_000_000,
   parameter bit BUTTON_ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_start_stop,
   input  logic              btn_lap_reset,
   input  logic              tick_in,
   input  logic [TIME_W-1:0] time_live,
   output logic              count_enable,
   output logic              count_clear,
   output logic [TIME_W-1:0] display_number,
   output logic              running,
   output logic              lap_hold
);

   state_t            state;
   state_t            state_next;
   logic              clear_next;
   logic              capture;
   logic              start_stop;
   logic              lap_reset;
   logic [TIME_W-1:0] lap_value;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BUTTON_ACTIVE_LOW)
   ) u_start_stop (
      .clk    (clk),
      .rst    (rst),
      .in     (btn_start_stop),
      .pressed(start_stop)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BUTTON_ACTIVE_LOW)
   ) u_lap_reset (
      .clk    (clk),
      .rst    (rst),
      .in     (btn_lap_reset),
      .pressed(lap_reset)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count_clear <= 1'b0;
         lap_value   <= '0;
      end else begin
         state       <= state_next;
         count_clear <= clear_next;
         if (capture) begin
            lap_value <= time_live;
         end
      end
   end

   // start_stop is examined first so a coincident lap_reset press is dropped.
   always_comb begin
      state_next = state;
      clear_next = 1'b0;
      capture    = 1'b0;
      if (start_stop) begin
         case (state)
            IDLE:    state_next = RUNNING;
            RUNNING: state_next = PAUSED;
            PAUSED:  state_next = RUNNING;
            LAP:     state_next = PAUSED;
            default: state_next = IDLE;
         endcase
      end else if (lap_reset) begin
         case (state)
            IDLE: begin
               clear_next = 1'b1;
            end
            RUNNING: begin
               state_next = LAP;
               capture    = 1'b1;
            end
            LAP: begin
               state_next = RUNNING;
            end
            PAUSED: begin
               state_next = IDLE;
               clear_next = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign running        = (state == RUNNING) || (state == LAP);
   assign lap_hold       = (state == LAP);
   assign count_enable   = tick_in & running;
   assign display_number = lap_hold ? lap_value : time_live;

endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench for stopwatch_control: stimulus pushes the expected
// per-cycle outputs of a behavioural model, a monitor pops and compares.
module tb_stopwatch_control;

   localparam int DC   = 4;
   localparam int MAXC = 12000;

   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} m_state_t;

   typedef struct packed {
      logic        ce;
      logic        cc;
      logic [15:0] disp;
      logic        run;
      logic        lap;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        btn_start_stop;
   logic        btn_lap_reset;
   logic        tick_in;
   logic [15:0] time_live;
   logic        count_enable;
   logic        count_clear;
   logic [15:0] display_number;
   logic        running;
   logic        lap_hold;

   exp_t        exp_q[$];
   int          nTotal = 0;
   int          nBad   = 0;
   int          cyc    = 0;

   m_state_t    mst;
   logic [15:0] mlap;
   bit          mclear;
   bit          pend_ss [MAXC];
   bit          pend_lr [MAXC];
   bit          tl_rand;
   logic [15:0] tl_cur;

   stopwatch_control #(
      .DEBOUNCE_CYCLES  (DC),
      .BUTTON_ACTIVE_LOW(1'b0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_start_stop(btn_start_stop),
      .btn_lap_reset (btn_lap_reset),
      .tick_in       (tick_in),
      .time_live     (time_live),
      .count_enable  (count_enable),
      .count_clear   (count_clear),
      .display_number(display_number),
      .running       (running),
      .lap_hold      (lap_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      for (int d = 0; d < 4; d++) begin
         v[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
      nTotal++;
      if (act !== expv) begin
         nBad++;
         $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, expv);
      end
   endtask

   // One clock cycle: drive inputs, record what the model says the outputs
   // must be during this cycle, then advance the model across the next edge.
   task automatic applyStimulus(input bit ss, input bit lr, input bit tk, input logic [15:0] tl, input bit r);
      exp_t e;
      btn_start_stop = ss;
      btn_lap_reset  = lr;
      tick_in        = tk;
      time_live      = tl;
      rst            = r;

      e.run  = (mst == M_RUN) || (mst == M_LAP);
      e.lap  = (mst == M_LAP);
      e.ce   = tk && e.run;
      e.cc   = mclear;
      e.disp = e.lap ? mlap : tl;
      exp_q.push_back(e);

      if (r) begin
         mst    = M_IDLE;
         mlap   = 16'h0000;
         mclear = 1'b0;
         for (int k = cyc; k < cyc + DC + 8 && k < MAXC; k++) begin
            pend_ss[k] = 1'b0;
            pend_lr[k] = 1'b0;
         end
      end else begin
         mclear = 1'b0;
         if (pend_ss[cyc]) begin
            if (mst == M_RUN) mst = M_PAUSE;
            else if (mst == M_LAP) mst = M_PAUSE;
            else mst = M_RUN;
         end else if (pend_lr[cyc]) begin
            if (mst == M_IDLE) begin
               mclear = 1'b1;
            end else if (mst == M_RUN) begin
               mst  = M_LAP;
               mlap = tl;
            end else if (mst == M_LAP) begin
               mst = M_RUN;
            end else begin
               mst    = M_IDLE;
               mclear = 1'b1;
            end
         end
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   // kind: 0 start_stop, 1 lap_reset, 2 both together, 3 start_stop press
   // cut short by a one-cycle reset, 4 idle for 'hold' cycles.
   task automatic runEvent(input int kind, input int hold);
      int len;
      bit ss;
      bit lr;
      bit r;
      len = (kind == 4) ? hold : hold + DC + 6;
      for (int i = 0; i < len; i++) begin
         ss = 1'b0;
         lr = 1'b0;
         r  = 1'b0;
         if (kind != 4 && i < hold) begin
            ss = (kind == 0) || (kind == 2) || (kind == 3);
            lr = (kind == 1) || (kind == 2);
         end
         if (kind == 3 && i == DC) r = 1'b1;
         if (i == 0 && hold >= DC && kind < 3 && cyc + DC + 3 < MAXC) begin
            if (ss) pend_ss[cyc + DC + 3] = 1'b1;
            if (lr) pend_lr[cyc + DC + 3] = 1'b1;
         end
         applyStimulus(ss, lr, ($urandom_range(0, 2) == 0), tl_rand ? rand_bcd() : tl_cur, r);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("count_enable", 16'(count_enable), 16'(e.ce));
            checkOutput("count_clear", 16'(count_clear), 16'(e.cc));
            checkOutput("display_number", display_number, e.disp);
            checkOutput("running", 16'(running), 16'(e.run));
            checkOutput("lap_hold", 16'(lap_hold), 16'(e.lap));
         end
      end
   end

   initial begin : stimulus
      btn_start_stop = 1'b0;
      btn_lap_reset  = 1'b0;
      tick_in        = 1'b0;
      time_live      = 16'h0000;
      rst            = 1'b1;
      mst            = M_IDLE;
      mlap           = 16'h0000;
      mclear         = 1'b0;
      tl_rand        = 1'b1;
      tl_cur         = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      cyc = 2;

      // Directed walk through the main scenarios first.
      runEvent(0, DC - 1);
      runEvent(0, 20);
      tl_rand = 1'b0;
      tl_cur  = 16'h0123;
      runEvent(1, DC + 2);
      tl_cur  = 16'h0130;
      runEvent(4, 5);
      runEvent(1, DC);
      tl_rand = 1'b1;
      runEvent(0, DC + 1);
      runEvent(1, DC + 3);
      runEvent(2, DC + 2);
      runEvent(1, DC);
      runEvent(3, DC + 1);
      runEvent(4, 20);

      // Randomised sequence of presses, glitches, simultaneous presses, resets.
      for (int n = 0; n < 160; n++) begin
         int pick;
         pick = $urandom_range(0, 9);
         if (pick < 3)       runEvent(0, $urandom_range(DC, 12));
         else if (pick < 6)  runEvent(1, $urandom_range(DC, 12));
         else if (pick == 6) runEvent(2, $urandom_range(DC, 12));
         else if (pick == 7) runEvent($urandom_range(0, 1), $urandom_range(1, DC - 1));
         else if (pick == 8) runEvent(3, DC + 1);
         else                runEvent(4, $urandom_range(1, 6));
      end

      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule
